// File: rtl/img_src_if.sv
// Pixel type and the valid/ready stream interface carrying it from img_src
// to the filtering front end.
package pixel_pkg;
  typedef struct packed {
    logic [7:0] red;
    logic [7:0] grn;
    logic [7:0] blu;
  } pixel_t;
endpackage

interface axis_if;
  pixel_pkg::pixel_t data;
  logic              vld;
  logic              rdy;

  modport master (output data, output vld, input rdy);
  modport slave  (input data, input vld, output rdy);
endinterface

// File: rtl/img_src.sv
// Frame-streaming source: reads one IMG_W x IMG_H frame in raster order from a
// synchronous frame memory and streams it out with line/done strobes for img_buf.
module img_src #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [23:0]       mem_rdata,
  axis_if.master            axis_o,
  output logic              line,
  output logic              done
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, EOL, EOF} state_t;

  state_t             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               rd_all_q, rd_all_d;
  logic               rd_vld_q, rd_vld_d;
  logic [1:0]         cnt_q, cnt_d;
  pixel_pkg::pixel_t  buf0_q, buf0_d;
  pixel_pkg::pixel_t  buf1_q, buf1_d;

  pixel_pkg::pixel_t  rd_pix;
  pixel_pkg::pixel_t  out_data;
  logic               out_vld;
  logic               ok;
  logic [2:0]         occ;
  logic               last_col;
  logic               last_row;

  assign rd_pix   = pixel_pkg::pixel_t'(mem_rdata);
  assign last_col = (col_q == COL_W'(IMG_W - 1));
  assign last_row = (row_q == ROW_W'(IMG_H - 1));

  // A pixel returning from memory this cycle is offered directly when the skid
  // buffer is empty; otherwise the buffer head goes out and the return queues.
  always_comb begin
    out_vld  = (state_q == RUN) && ((cnt_q != 2'd0) || rd_vld_q);
    out_data = (cnt_q != 2'd0) ? buf0_q : rd_pix;
    ok       = out_vld && axis_o.rdy;
    occ      = 3'(cnt_q) + 3'(rd_vld_q);
    mem_en   = ((state_q == RUN) || (state_q == EOL)) && !rd_all_q && (occ < 3'd2);
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    addr_d   = addr_q;
    rd_all_d = rd_all_q;
    rd_vld_d = mem_en;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          col_d    = '0;
          row_d    = '0;
          addr_d   = '0;
          rd_all_d = 1'b0;
        end
      end
      RUN: begin
        if (ok) begin
          if (last_col) begin
            col_d = '0;
            if (last_row) begin
              state_d = EOF;
            end else begin
              state_d = EOL;
              row_d   = row_q + ROW_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      EOL: begin
        state_d = RUN;
      end
      EOF: begin
        state_d = IDLE;
        addr_d  = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Address holds on the last pixel once issued; only frame completion wraps it.
    if (mem_en) begin
      if (addr_q == LAST_ADDR) begin
        rd_all_d = 1'b1;
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    buf0_d = buf0_q;
    buf1_d = buf1_q;

    if (ok && (cnt_q != 2'd0)) begin
      buf0_d = buf1_q;
      cnt_d  = cnt_q - 2'd1;
    end

    if (rd_vld_q && !(ok && (cnt_q == 2'd0))) begin
      if (cnt_d == 2'd0) begin
        buf0_d = rd_pix;
      end else begin
        buf1_d = rd_pix;
      end
      cnt_d = cnt_d + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      col_q    <= '0;
      row_q    <= '0;
      addr_q   <= '0;
      rd_all_q <= 1'b0;
      rd_vld_q <= 1'b0;
      cnt_q    <= 2'd0;
      buf0_q   <= '0;
      buf1_q   <= '0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      row_q    <= row_d;
      addr_q   <= addr_d;
      rd_all_q <= rd_all_d;
      rd_vld_q <= rd_vld_d;
      cnt_q    <= cnt_d;
      buf0_q   <= buf0_d;
      buf1_q   <= buf1_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign line        = (state_q == EOL) || (state_q == EOF);
  assign done        = (state_q == EOF);
  assign mem_addr    = addr_q;
  assign axis_o.vld  = out_vld;
  assign axis_o.data = out_data;

endmodule

// File: tb/tb_img_src.sv
// Scoreboard bench for img_src on a 4x3 frame: stimulus queues expected pixels,
// a negedge monitor pops and compares them and checks strobes, reads and holds.
module tb_img_src;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int AW   = 4;
  localparam int NPIX = W * H;

  logic          clk = 1'b0;
  logic          rst;
  logic          start = 1'b0;
  logic          busy;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [23:0]   mem_rdata = 24'h0;
  logic          line;
  logic          done;
  logic          rdy = 1'b1;

  axis_if axis ();
  assign axis.rdy = rdy;

  img_src #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .axis_o    (axis),
    .line      (line),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Distinct bytes per channel so a channel swap is visible.
  function automatic logic [23:0] pix_of(input int i);
    logic [7:0] r, g, b;
    r = 8'(i);
    g = 8'(i + 'h40);
    b = 8'(i ^ 'hA0);
    return {r, g, b};
  endfunction

  // Synchronous frame memory; junk when not enabled so stray captures show up.
  always @(posedge clk) begin
    mem_rdata <= mem_en ? pix_of(int'(mem_addr)) : 24'hDEAD5A;
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [23:0] exp_q[$];
  int          rdy_mode = 0;
  logic        timing_chk = 1'b0;
  int          cyc = 0;
  int          f_oks = 0;
  int          f_lines = 0;
  int          f_reads = 0;
  int          first_cyc = -1;
  int          exp_addr = 0;
  int          dones = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulse start in the current cycle; queue the frame when it should be accepted.
  task automatic applyStimulus(input bit accept, input bit check_lat);
    start = 1'b1;
    if (accept) begin
      for (int i = 0; i < NPIX; i++) exp_q.push_back(pix_of(i));
    end
    @(posedge clk); #1;
    start = 1'b0;
    if (check_lat) begin
      @(negedge clk);
      checkOutput("lat_cycle1_vld", 32'(axis.vld), 32'd0);
      checkOutput("busy_after_start", 32'(busy), 32'd1);
      @(negedge clk);
      checkOutput("lat_cycle2_vld", 32'(axis.vld), 32'd1);
    end
  endtask

  task automatic waitDone(input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL wait_done: got timeout expected done within %0d cycles", limit);
    end
  endtask

  task automatic waitOks(input int target, input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(posedge clk); #1;
      if (f_oks >= target) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL wait_oks: got %0d expected %0d", f_oks, target);
    end
  endtask

  // Ready driver: 0 = always ready, 1 = random, 2 = stalled.
  initial begin
    forever begin
      @(posedge clk); #2;
      case (rdy_mode)
        1:       rdy = 1'($urandom_range(0, 1));
        2:       rdy = 1'b0;
        default: rdy = 1'b1;
      endcase
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic        prev_vld;
    logic        prev_rdy;
    logic [23:0] prev_data;
    logic [23:0] e;
    prev_vld  = 1'b0;
    prev_rdy  = 1'b0;
    prev_data = 24'h0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        f_oks     = 0;
        f_lines   = 0;
        f_reads   = 0;
        first_cyc = -1;
        exp_addr  = 0;
        prev_vld  = 1'b0;
        exp_q.delete();
      end else begin
        if (prev_vld && !prev_rdy) begin
          checkOutput("hold_vld", 32'(axis.vld), 32'd1);
          checkOutput("hold_data", 32'(axis.data), 32'(prev_data));
        end
        if (axis.vld && first_cyc < 0) first_cyc = cyc;
        if (axis.vld && rdy) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL unexpected_pixel: got %0h expected none", axis.data);
          end else begin
            e = exp_q.pop_front();
            checkOutput("pixel", 32'(axis.data), 32'(e));
          end
          f_oks++;
        end
        if (mem_en) begin
          checkOutput("rd_addr", 32'(mem_addr), 32'(exp_addr));
          exp_addr++;
          f_reads++;
        end
        if (line) begin
          checkOutput("line_bubble_vld", 32'(axis.vld), 32'd0);
          checkOutput("line_pos", 32'(f_oks), 32'((f_lines + 1) * W));
          checkOutput("done_on_last_line", 32'(done), 32'(f_lines + 1 == H));
          f_lines++;
        end else if (done) begin
          checkOutput("done_without_line", 32'(line), 32'd1);
        end
        if (done) begin
          dones++;
          checkOutput("frame_pixels", 32'(f_oks), 32'(NPIX));
          checkOutput("frame_lines", 32'(f_lines), 32'(H));
          checkOutput("frame_reads", 32'(f_reads), 32'(NPIX));
          checkOutput("queue_empty_at_done", 32'(exp_q.size()), 32'd0);
          if (timing_chk) begin
            checkOutput("first_vld_to_done", 32'(cyc - first_cyc), 32'(NPIX + H - 1));
          end
          f_oks     = 0;
          f_lines   = 0;
          f_reads   = 0;
          first_cyc = -1;
          exp_addr  = 0;
        end
        prev_vld  = axis.vld;
        prev_rdy  = rdy;
        prev_data = axis.data;
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dones_before;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_vld", 32'(axis.vld), 32'd0);
    checkOutput("rst_line", 32'(line), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] frame with rdy held high, then a back-to-back frame");
    timing_chk = 1'b1;
    applyStimulus(1'b1, 1'b1);
    waitDone(200);
    @(posedge clk); #1;
    checkOutput("busy_after_done", 32'(busy), 32'd0);
    applyStimulus(1'b1, 1'b1);
    waitDone(200);
    @(posedge clk); #1;

    $display("[TB] frame with random rdy");
    timing_chk = 1'b0;
    rdy_mode   = 1;
    applyStimulus(1'b1, 1'b0);
    waitDone(1000);
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] start pulsed again mid-frame");
    timing_chk   = 1'b1;
    dones_before = dones;
    applyStimulus(1'b1, 1'b1);
    waitOks(5, 100);
    applyStimulus(1'b0, 1'b0);
    waitDone(200);
    repeat (30) @(posedge clk);
    #1;
    checkOutput("single_done", 32'(dones - dones_before), 32'd1);

    $display("[TB] reset with pixel 6 pending");
    applyStimulus(1'b1, 1'b1);
    waitOks(6, 100);
    rdy_mode = 2;
    @(negedge clk);
    checkOutput("pending_vld", 32'(axis.vld), 32'd1);
    checkOutput("pending_data", 32'(axis.data), 32'(pix_of(6)));
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_mem_en", 32'(mem_en), 32'd0);
    checkOutput("abort_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("abort_vld", 32'(axis.vld), 32'd0);
    checkOutput("abort_line", 32'(line), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    rdy_mode = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("post_rst_vld", 32'(axis.vld), 32'd0);
      checkOutput("post_rst_line", 32'(line), 32'd0);
      checkOutput("post_rst_busy", 32'(busy), 32'd0);
    end
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b1);
    waitDone(200);
    repeat (5) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/img_src.md
Name: img_src

Overview:
- Frame-streaming source that feeds img_buf.
- On start, reads one IMG_W x IMG_H frame from a synchronous frame memory in raster order.
- Emits pixels on an axis_if master stream and generates the line and done strobes with the timing img_buf needs.
- Sits between the frame store (BRAM or DDR read cache) and the filtering front end.

Parameters:
- IMG_W, 640: pixels per row.
- IMG_H, 480: rows per frame.
- ADDR_W, 19: frame memory address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  one-cycle request to stream one frame; ignored while busy=1.
- busy  output  1  high from the cycle after start is accepted until the cycle after done.
- mem_en  output  1  frame memory read enable.
- mem_addr  output  ADDR_W  frame memory read address, linear raster (row*IMG_W + col).
- mem_rdata  input  24  read data {red,grn,blu}; valid exactly 1 cycle after a cycle with mem_en=1.
- axis_o  axis_if.master  pixel_pkg::pixel_t  pixel stream (data, vld out; rdy in; ok = vld & rdy).
- line  output  1  one-cycle end-of-row strobe.
- done  output  1  one-cycle end-of-frame strobe.

Behaviour:
- Reset values: busy=0, mem_en=0, mem_addr=0, axis_o.vld=0, line=0, done=0; all counters 0; skid buffer empty; FSM=IDLE.
- Reset mid-frame aborts immediately. No line/done is produced for the aborted frame, and no pixel is presented after reset release until a new start.
- FSM states: IDLE, RUN, EOL, EOF.
  - IDLE -> RUN on start. Clears col/row counters and the read address.
  - RUN -> EOL on the ok of the pixel with col=IMG_W-1 and row<IMG_H-1.
  - RUN -> EOF on the ok of the pixel with col=IMG_W-1 and row=IMG_H-1.
  - EOL -> RUN after exactly 1 cycle.
  - EOF -> IDLE after exactly 1 cycle.
- line=1 only in EOL and EOF. done=1 only in EOF. line and done coincide on the last row. Neither is asserted in the same cycle as a pixel ok.
- axis_o.vld=0 in EOL, EOF and IDLE. This forced bubble is required because img_buf resets its write address on line.
- Memory reads use addresses 0..IMG_W*IMG_H-1, each issued exactly once per frame, in order, with no read past the last pixel.
- Prefetch with a 2-entry skid buffer, counting reads in flight:
  - mem_en=1 only when in RUN/EOL, addresses remain, and (entries held + reads in flight) < 2.
  - Reads may be issued during EOL so the next row starts without an extra bubble.
- Throughput with rdy held at 1:
  - First vld 2 cycles after start is sampled.
  - Then 1 pixel/cycle within a row, plus exactly 1 bubble cycle (EOL) per row boundary.
  - Frame duration from first vld to done is IMG_W*IMG_H + IMG_H - 1 cycles.
- AXIS rules:
  - Once vld=1, data and vld hold stable until ok.
  - rdy may toggle arbitrarily; no pixel is dropped, duplicated or reordered.
  - axis_o.data.red/grn/blu = mem_rdata[23:16]/[15:8]/[7:0].
- Counters:
  - col counts 0..IMG_W-1 and row counts 0..IMG_H-1, advancing on ok.
  - col wraps to 0 on EOL entry; row increments on EOL entry.
  - The read address wraps only by frame completion, never mid-frame.
- start while busy=1 is ignored.
- Back-to-back frames: start is accepted in any cycle with busy=0, including the cycle right after done.
- Simultaneous rst and start: rst wins.

Test Plan:
- IMG_W=4, IMG_H=3, memory[i]=i, rdy=1, pulse start:
  - pixels 0..11 in order; first vld 2 cycles after start.
  - line high once after pixels 3, 7 and 11; done high only with the final line.
  - done occurs 14 cycles after first vld.
- Same frame, rdy pseudo-random 50% duty -> identical pixel sequence; data stable across every stalled cycle; vld never high in a line cycle; exactly 12 ok's.
- start pulsed again mid-frame (at pixel 5) -> ignored; exactly 12 pixels and 1 done; mem_addr never exceeds 11.
- rst asserted while pixel 6 is pending with rdy=0 -> all outputs 0 asynchronously; no line/done. A new start yields pixels from 0.
- start asserted in the cycle after done -> second frame streams 0..11 with correct line/done.
- IMG_W=640, IMG_H=480 into an instantiated img_buf, rdy=1 -> 480 line pulses, 1 done; img_buf receives 307200 pixels with no write-address corruption.
